// File: rtl/acc_scheduler.sv
// Round-robin scheduler sharing one accumulator among NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define ACC_SCHED_SATURATE_EN for unsigned-saturating accumulation with a sticky ovf flag.
module acc_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          ck,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          clear,
  output logic [DATA_WIDTH-1:0]         acc_data,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy,
  output logic                          ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_clr_pend;
  logic [ID_WIDTH-1:0]   r_rr_ptr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_opnd;

  logic                  w_clr_act;
  logic                  w_found;
  logic                  w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic [ID_WIDTH-1:0]   w_win;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_sum;

  // A clear seen this cycle counts as pending so it beats a same-cycle request.
  assign w_clr_act = r_clr_pend | clear;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_WIDTH'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_grant   = (r_state == IDLE) && !w_clr_act && w_found;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign w_ptr_nxt = (w_win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : (w_win + ID_WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef ACC_SCHED_SATURATE_EN
  logic [DATA_WIDTH:0] w_add;
  logic                r_ovf;

  // MSB of the result flags that the sum was clamped.
  function automatic logic [DATA_WIDTH:0] f_sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_WIDTH] ? {1'b1, {DATA_WIDTH{1'b1}}} : s;
  endfunction

  assign w_add = f_sat_add(r_acc, r_opnd);
  assign w_sum = w_add[DATA_WIDTH-1:0];

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && w_clr_act) begin
      r_ovf <= 1'b0;
    end else if (r_state == EXEC && w_add[DATA_WIDTH]) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  function automatic logic [DATA_WIDTH-1:0] f_wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  assign w_sum = f_wrap_add(r_acc, r_opnd);
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_rr_ptr   <= '0;
      r_clr_pend <= 1'b0;
      r_id       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_clr_act) begin
        r_acc      <= '0;
        r_clr_pend <= 1'b0;
      end else if (clear) begin
        r_clr_pend <= 1'b1;
      end
      if (w_grant) begin
        r_rr_ptr <= w_ptr_nxt;
        r_id     <= w_win;
      end
      if (r_state == EXEC) begin
        r_acc <= w_sum;
      end
    end
  end

  // Operand is pure data: captured on the handshake only, no reset needed.
  always_ff @(posedge ck) begin
    if (w_grant) begin
      r_opnd <= req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign acc_data  = r_acc;
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/acc_scheduler.md
ACC_SCHEDULER -- requirements
Module: acc_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the accumulator, legal range 2..16.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32: width of operands and accumulator.
REQ-003 The block SHALL have parameter ID_WIDTH, default $clog2(NUM_REQ): width of the requester index.
REQ-004 ck  input  1  single clock, all state on rising edge.
REQ-005 arst  input  1  reset, asynchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-008 req_data  input  NUM_REQ*DATA_WIDTH  operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 clear  input  1  synchronous request to zero the accumulator.
REQ-010 acc_data  output  DATA_WIDTH  current accumulator value.
REQ-011 rsp_valid  output  1  one-cycle pulse: operation complete.
REQ-012 rsp_id  output  ID_WIDTH  index of the requester whose operation completed.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 ovf  output  1  sticky saturation flag.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC and RESP, and only the transitions IDLE->EXEC, EXEC->RESP and RESP->IDLE.
REQ-016 In IDLE with no pending clear and any req_valid set, the block SHALL assert req_ready for exactly one winner in that same cycle, latch its operand and index, and go to EXEC.
REQ-017 The winner SHALL be the first requester with req_valid set, searching round-robin from rr_ptr upward with wrap from NUM_REQ-1 to 0.
REQ-018 After each grant, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-019 req_ready SHALL be all-zero in EXEC, in RESP, and in IDLE while a clear is pending.
REQ-020 In EXEC the block SHALL update acc_data to acc_data + operand, truncated to DATA_WIDTH bits (wraps modulo 2^DATA_WIDTH), then go to RESP.
REQ-021 In RESP the block SHALL assert rsp_valid for one cycle, with rsp_id equal to the latched index and acc_data already holding the updated value, then go to IDLE.
REQ-022 Latency SHALL be fixed: handshake in cycle N, accumulator updated at the edge ending cycle N+1, rsp_valid in cycle N+2, next grant no earlier than cycle N+3.
REQ-023 A clear sampled in any state SHALL set a pending flag.
REQ-024 In IDLE, a pending clear SHALL zero acc_data and drop the flag, with no grant issued in that cycle.
REQ-025 A clear arriving in EXEC or RESP SHALL not affect the operation in flight.
REQ-026 clear and req_valid in the same IDLE cycle: the clear SHALL win and the request SHALL be granted no earlier than the next cycle.
REQ-027 req_valid deasserted without a handshake SHALL cause no state change.
REQ-028 req_data SHALL be sampled only on the handshake cycle.

Reset
REQ-029 While arst is high the block SHALL asynchronously force: state=IDLE, acc_data=0, rr_ptr=0, pending clear=0, latched index=0, rsp_valid=0, rsp_id=0, req_ready=0, busy=0, ovf=0.
REQ-030 An arst during EXEC or RESP SHALL discard the operation in flight with no rsp_valid emitted.
REQ-031 Arbitration SHALL resume from requester 0 on the first ck edge after arst deasserts.

Configuration
REQ-032 With the macro ACC_SCHED_SATURATE_EN defined, the EXEC addition SHALL be unsigned-saturating: if the result exceeds 2^DATA_WIDTH-1, acc_data SHALL be set to all ones and ovf SHALL be set.
REQ-033 With ACC_SCHED_SATURATE_EN defined, ovf SHALL remain set until arst or an applied clear.
REQ-034 Without ACC_SCHED_SATURATE_EN, the addition SHALL wrap per REQ-020, ovf SHALL be tied to 0, and no saturation logic SHALL be present.

Verification
REQ-035 Reset then single request: req_valid=4'b0100, operand 5 -> req_ready=4'b0100 in the same cycle; rsp_valid two cycles later with rsp_id=2 and acc_data=5.
REQ-036 Fairness: all four requesters held valid with operand 1 for 8 operations -> grant order 0,1,2,3,0,1,2,3; acc_data=8; each operation takes 3 cycles.
REQ-037 Clear collision: clear=1 and req_valid=4'b0001 in the same IDLE cycle with acc_data=7 -> acc_data=0 and no ready that cycle; grant in the next cycle.
REQ-038 Wrap, macro undefined: acc_data=32'hFFFF_FFFE plus operand 3 -> acc_data=1, ovf=0.
REQ-039 Saturation, macro defined: the same stimulus as REQ-038 -> acc_data=32'hFFFF_FFFF and ovf=1; ovf stays 1 until a clear is applied.
REQ-040 Reset mid-operation: arst pulsed in EXEC -> no rsp_valid; acc_data=0; the next grant goes to the lowest valid index.
